game_ctrl: RTL and testbench

//  Sequential controller directly upstream of the combinational minesweeper board. Owns the registered

---
 rtl/game_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_game_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl: registered bomb/reveal/cursor grids feeding the minesweeper board.
// Define FLOOD_FILL_EN to auto-reveal the neighbourhood of zero-count cells.
module game_ctrl #(
    parameter int GRID_SIZE  = 3,
    parameter int STATE_SIZE = 4,
    parameter int NUM_BOMBS  = 2,
    parameter int LFSR_W     = 8,
    localparam int N = GRID_SIZE * GRID_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_game,
    input  logic [LFSR_W-1:0]       seed,
    input  logic                    bomb_load,
    input  logic [N-1:0]            bomb_mask,
    input  logic                    move_req,
    input  logic [1:0]              move_dir,
    input  logic                    reveal_req,
    input  logic [N-1:0]            next_cursor,
    input  logic [STATE_SIZE*N-1:0] cell_states,
    output logic [N-1:0]            bomb_grid,
    output logic [N-1:0]            reveal_grid,
    output logic [N-1:0]            cursor_grid,
    output logic                    board_move,
    output logic [1:0]              board_dir,
    output logic [2:0]              st,
    output logic                    busy
);

    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW = $clog2(NUM_BOMBS + 1);

    function automatic logic [31:0] taps_for(int w);
        logic [31:0] t;
        case (w)
            4:       t = 32'h0000_000C;
            5:       t = 32'h0000_0014;
            6:       t = 32'h0000_0030;
            7:       t = 32'h0000_0060;
            8:       t = 32'h0000_00B8;
            9:       t = 32'h0000_0110;
            10:      t = 32'h0000_0240;
            11:      t = 32'h0000_0500;
            12:      t = 32'h0000_0829;
            13:      t = 32'h0000_100D;
            14:      t = 32'h0000_2015;
            15:      t = 32'h0000_6000;
            16:      t = 32'h0000_D008;
            default: t = 32'h0000_00B8;
        endcase
        return t;
    endfunction

    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(taps_for(LFSR_W));
    localparam logic [N-1:0]      ONE      = N'(1);
    localparam logic [N-1:0]      TOP      = ONE << (N - 1);
    localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(NUM_BOMBS - 1);

    if (NUM_BOMBS >= N) begin : g_bad_bombs
        $error("game_ctrl: NUM_BOMBS must be smaller than the cell count");
    end
    if ((2 ** LFSR_W) < N) begin : g_bad_lfsr
        $error("game_ctrl: LFSR too narrow to address every cell");
    end
    if (LFSR_W < 4 || LFSR_W > 16) begin : g_bad_taps
        $error("game_ctrl: no maximal-length taps for this LFSR width");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLACE = 3'd1,
        PLAY  = 3'd2,
        FLOOD = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    state_t            st_q, st_n;
    logic [N-1:0]      bomb_q, bomb_n;
    logic [N-1:0]      rev_q, rev_n;
    logic [N-1:0]      cur_q, cur_n;
    logic [LFSR_W-1:0] lfsr_q, lfsr_n;
    logic [CNTW-1:0]   cnt_q, cnt_n;

    logic [CW-1:0] cand;
    logic [N-1:0]  cand_oh;
    logic          cand_ok;

    // candidate cell for placement: must exist, be free and not under the cursor
    assign cand    = lfsr_q[CW-1:0];
    assign cand_oh = ONE << cand;
    assign cand_ok = (|cand_oh) && !(|(cand_oh & (bomb_q | cur_q)));

`ifdef FLOOD_FILL_EN
    logic [N-1:0] zero_cells;
    logic [N-1:0] flood_add;
    logic         cur_zero;

    function automatic logic near(int a, int b);
        int dr, dc;
        dr = (a / GRID_SIZE) - (b / GRID_SIZE);
        dc = (a % GRID_SIZE) - (b % GRID_SIZE);
        return (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1);
    endfunction

    // cells to add this flood cycle: neighbours of revealed safe zero cells
    always_comb begin
        zero_cells = '0;
        flood_add  = '0;
        for (int j = 0; j < N; j++) begin
            zero_cells[j] = (cell_states[j*STATE_SIZE +: STATE_SIZE] == '0);
        end
        cur_zero = |(cur_q & zero_cells);
        for (int j = 0; j < N; j++) begin
            if (rev_q[j] && !bomb_q[j] && zero_cells[j]) begin
                for (int k = 0; k < N; k++) begin
                    if (near(j, k)) flood_add[k] = 1'b1;
                end
            end
        end
    end
`else
    logic unused_states;
    assign unused_states = ^cell_states;
`endif

    // next-state and next-grid decode
    always_comb begin
        st_n   = st_q;
        bomb_n = bomb_q;
        rev_n  = rev_q;
        cur_n  = cur_q;
        lfsr_n = lfsr_q;
        cnt_n  = cnt_q;
        if (new_game) begin
            rev_n  = '0;
            cur_n  = TOP;
            lfsr_n = (seed == '0) ? LFSR_W'(1) : seed;
            cnt_n  = '0;
            if (bomb_load) begin
                bomb_n = bomb_mask;
                st_n   = PLAY;
            end else begin
                bomb_n = '0;
                st_n   = PLACE;
            end
        end else begin
            unique case (st_q)
                PLACE: begin
                    lfsr_n = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
                    if (cand_ok) begin
                        bomb_n = bomb_q | cand_oh;
                        cnt_n  = cnt_q + CNTW'(1);
                        if (cnt_q == CNT_LAST) st_n = PLAY;
                    end
                end
                PLAY: begin
                    if (&(rev_q | bomb_q)) begin
                        st_n = WIN;
                    end else if (reveal_req) begin
                        if (|(cur_q & bomb_q)) begin
                            rev_n = '1;
                            st_n  = LOSE;
                        end else if (!(|(cur_q & rev_q))) begin
                            rev_n = rev_q | cur_q;
`ifdef FLOOD_FILL_EN
                            if (cur_zero) st_n = FLOOD;
`endif
                        end
                    end else if (move_req) begin
                        cur_n = next_cursor;
                    end
                end
`ifdef FLOOD_FILL_EN
                FLOOD: begin
                    rev_n = rev_q | flood_add;
                    if (!(|(flood_add & ~rev_q))) st_n = PLAY;
                end
`endif
                default: ;
            endcase
        end
    end

    // state and grid registers
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= IDLE;
            bomb_q <= '0;
            rev_q  <= '0;
            cur_q  <= TOP;
            lfsr_q <= LFSR_W'(1);
            cnt_q  <= '0;
        end else begin
            st_q   <= st_n;
            bomb_q <= bomb_n;
            rev_q  <= rev_n;
            cur_q  <= cur_n;
            lfsr_q <= lfsr_n;
            cnt_q  <= cnt_n;
        end
    end

    assign bomb_grid   = bomb_q;
    assign reveal_grid = rev_q;
    assign cursor_grid = cur_q;
    assign board_move  = move_req & (st_q == PLAY) & ~reveal_req;
    assign board_dir   = move_dir;
    assign st          = st_q;
    assign busy        = (st_q == PLACE) || (st_q == FLOOD);

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and random checks of game_ctrl against a row/column
// game model, with a behavioural minesweeper board closing the loop.
module tb_game_ctrl;
    localparam int G  = 3;
    localparam int N  = 9;
    localparam int SS = 4;
    localparam int LW = 8;
    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          new_game;
    logic [LW-1:0] seed;
    logic          bomb_load;
    logic [N-1:0]  bomb_mask;
    logic          move_req;
    logic [1:0]    move_dir;
    logic          reveal_req;
    logic [N-1:0]  next_cursor;
    logic [SS*N-1:0] cell_states;
    logic [N-1:0]  bomb_grid;
    logic [N-1:0]  reveal_grid;
    logic [N-1:0]  cursor_grid;
    logic          board_move;
    logic [1:0]    board_dir;
    logic [2:0]    st;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // model: state 0..5, cursor as bit index, grids as bit vectors
    int            m_st;
    int            m_ci;
    int            m_cnt;
    logic [N-1:0]  m_bomb;
    logic [N-1:0]  m_rev;
    logic [LW-1:0] m_lfsr;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .seed       (seed),
        .bomb_load  (bomb_load),
        .bomb_mask  (bomb_mask),
        .move_req   (move_req),
        .move_dir   (move_dir),
        .reveal_req (reveal_req),
        .next_cursor(next_cursor),
        .cell_states(cell_states),
        .bomb_grid  (bomb_grid),
        .reveal_grid(reveal_grid),
        .cursor_grid(cursor_grid),
        .board_move (board_move),
        .board_dir  (board_dir),
        .st         (st),
        .busy       (busy)
    );

    function automatic int idx(int r, int c);
        return N - 1 - (r * G + c);
    endfunction

    function automatic logic [N-1:0] oh(int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int step_idx(int i, logic [1:0] d);
        int r, c;
        r = (N - 1 - i) / G;
        c = (N - 1 - i) % G;
        case (d)
            2'b00:   if (c < G - 1) c++;
            2'b01:   if (r > 0) r--;
            2'b10:   if (c > 0) c--;
            default: if (r < G - 1) r++;
        endcase
        return idx(r, c);
    endfunction

    function automatic logic near(int a, int b);
        int ra, ca, rb, cb;
        ra = (N - 1 - a) / G;
        ca = (N - 1 - a) % G;
        rb = (N - 1 - b) / G;
        cb = (N - 1 - b) % G;
        return (ra - rb <= 1) && (rb - ra <= 1) && (ca - cb <= 1) && (cb - ca <= 1);
    endfunction

    function automatic int nb(logic [N-1:0] b, int i);
        int n;
        n = 0;
        for (int k = 0; k < N; k++) begin
            if (k != i && near(i, k) && b[k]) n++;
        end
        return n;
    endfunction

    // behavioural board: neighbour counts and cursor stepping with walls
    always_comb begin
        cell_states = '0;
        for (int i = 0; i < N; i++) begin
            cell_states[i*SS +: SS] = bomb_grid[i] ? 4'd9 : 4'(nb(bomb_grid, i));
        end
    end

    always_comb begin
        next_cursor = cursor_grid;
        if (board_move) begin
            for (int i = 0; i < N; i++) begin
                if (cursor_grid[i]) next_cursor = oh(step_idx(i, board_dir));
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int cand;
        logic fb;
        logic [N-1:0] nr;
        if (reset) begin
            m_st = 0; m_ci = N - 1; m_cnt = 0;
            m_bomb = '0; m_rev = '0; m_lfsr = 8'd1;
        end else if (new_game) begin
            m_rev = '0; m_ci = N - 1; m_cnt = 0;
            m_lfsr = (seed == 8'd0) ? 8'd1 : seed;
            m_bomb = bomb_load ? bomb_mask : '0;
            m_st = bomb_load ? 2 : 1;
        end else begin
            case (m_st)
                1: begin
                    cand = int'(m_lfsr[3:0]);
                    if (cand < N && cand != m_ci && !m_bomb[cand]) begin
                        m_bomb[cand] = 1'b1;
                        m_cnt++;
                        if (m_cnt == NB) m_st = 2;
                    end
                    fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
                    m_lfsr = {m_lfsr[6:0], fb};
                end
                2: begin
                    if ((m_rev | m_bomb) == '1) begin
                        m_st = 4;
                    end else if (reveal_req) begin
                        if (m_bomb[m_ci]) begin
                            m_rev = '1;
                            m_st = 5;
                        end else if (!m_rev[m_ci]) begin
                            m_rev[m_ci] = 1'b1;
`ifdef FLOOD_FILL_EN
                            if (nb(m_bomb, m_ci) == 0) m_st = 3;
`endif
                        end
                    end else if (move_req) begin
                        m_ci = step_idx(m_ci, move_dir);
                    end
                end
                3: begin
                    nr = m_rev;
                    for (int j = 0; j < N; j++) begin
                        if (m_rev[j] && !m_bomb[j] && nb(m_bomb, j) == 0) begin
                            for (int k = 0; k < N; k++) begin
                                if (near(j, k)) nr[k] = 1'b1;
                            end
                        end
                    end
                    if (nr == m_rev) m_st = 2;
                    m_rev = nr;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        #1;
        check("board_move", 32'(board_move),
              32'(move_req && m_st == 2 && !reveal_req));
        check("board_dir", 32'(board_dir), 32'(move_dir));
        model_step();
        @(posedge clk);
        #1;
        check("st", 32'(st), 32'(m_st));
        check("bomb_grid", 32'(bomb_grid), 32'(m_bomb));
        check("reveal_grid", 32'(reveal_grid), 32'(m_rev));
        check("cursor_grid", 32'(cursor_grid), 32'(oh(m_ci)));
        check("busy", 32'(busy), 32'(m_st == 1 || m_st == 3));
    endtask

    task automatic go(bit ng, bit ld, logic [N-1:0] mk, logic [LW-1:0] sd,
                      bit mv, logic [1:0] d, bit rv);
        new_game = ng; bomb_load = ld; bomb_mask = mk; seed = sd;
        move_req = mv; move_dir = d; reveal_req = rv;
        tick();
        new_game = 1'b0; move_req = 1'b0; reveal_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; new_game = 1'b0; seed = '0; bomb_load = 1'b0;
        bomb_mask = '0; move_req = 1'b0; move_dir = 2'b00; reveal_req = 1'b0;
        m_st = 0; m_ci = N - 1; m_cnt = 0; m_bomb = '0; m_rev = '0; m_lfsr = 8'd1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_st", 32'(st), 32'd0);
        check("rst_cursor", 32'(cursor_grid), 32'h100);
        check("rst_reveal", 32'(reveal_grid), 32'h000);
        check("rst_busy", 32'(busy), 32'd0);

        // directed load and cursor walk
        go(1, 1, 9'h001, 8'd0, 0, 2'b00, 0);
        check("load_st", 32'(st), 32'd2);
        check("load_bomb", 32'(bomb_grid), 32'h001);
        check("load_cursor", 32'(cursor_grid), 32'h100);
        go(0, 0, 9'h0, 8'd0, 1, 2'b00, 0);
        check("move_right", 32'(cursor_grid), 32'h080);
        go(0, 0, 9'h0, 8'd0, 0, 2'b00, 0);
        go(0, 0, 9'h0, 8'd0, 1, 2'b11, 0);
        check("move_down", 32'(cursor_grid), 32'h010);
        go(0, 0, 9'h0, 8'd0, 1, 2'b00, 0);
        go(0, 0, 9'h0, 8'd0, 1, 2'b00, 0);

        // step onto the bomb and lose; later requests are ignored
        go(0, 0, 9'h0, 8'd0, 1, 2'b11, 0);
        go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        check("lose_st", 32'(st), 32'd5);
        check("lose_reveal", 32'(reveal_grid), 32'h1FF);
        go(0, 0, 9'h0, 8'd0, 1, 2'b10, 0);
        go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        check("lose_frozen", 32'(cursor_grid), 32'h001);

        // reveal every safe cell of mask 101
        go(1, 1, 9'h101, 8'd0, 0, 2'b00, 0);
        go(0, 0, 9'h0, 8'd0, 1, 2'b00, 0); go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        go(0, 0, 9'h0, 8'd0, 1, 2'b00, 0); go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        go(0, 0, 9'h0, 8'd0, 1, 2'b11, 0); go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        go(0, 0, 9'h0, 8'd0, 1, 2'b10, 0); go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        go(0, 0, 9'h0, 8'd0, 1, 2'b10, 0); go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        go(0, 0, 9'h0, 8'd0, 1, 2'b11, 0); go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
        go(0, 0, 9'h0, 8'd0, 1, 2'b00, 0); go(0, 0, 9'h0, 8'd0, 0, 2'b00, 1);
`ifndef FLOOD_FILL_EN
        check("pre_win_st", 32'(st), 32'd2);
        check("pre_win_reveal", 32'(reveal_grid), 32'h0FE);
`endif
        go(0, 0, 9'h0, 8'd0, 0, 2'b00, 0);
`ifndef FLOOD_FILL_EN
        check("win_st", 32'(st), 32'd4);
`endif

        // random placement from seed 0 (treated as 1)
        go(1, 0, 9'h0, 8'd0, 0, 2'b00, 0);
        check("place_st", 32'(st), 32'd1);
        check("place_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 300 && m_st == 1; i++) begin
            go(0, 0, 9'h0, 8'd0, $urandom_range(0, 1), 2'($urandom), 0);
        end
        check("place_done", 32'(st), 32'd2);
        check("place_count", 32'($countones(bomb_grid)), 32'd2);
        check("place_top_free", 32'(bomb_grid[8]), 32'd0);

        // reveal and move in the same cycle: move dropped
        go(0, 0, 9'h0, 8'd0, 1, 2'b00, 1);
        check("rv_mv_cursor", 32'(cursor_grid), 32'h100);
        check("rv_mv_reveal", 32'(reveal_grid[8]), 32'd1);
`ifdef FLOOD_FILL_EN
        if (m_st == 3) begin
            go(1, 0, 9'h0, 8'h33, 0, 2'b00, 0);
            check("flood_abort_st", 32'(st), 32'd1);
            check("flood_abort_rev", 32'(reveal_grid), 32'h000);
        end
`endif

        // reset in the middle of placement
        go(1, 0, 9'h0, 8'h5A, 0, 2'b00, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("place_reset_st", 32'(st), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            new_game   = ($urandom_range(0, 24) == 0);
            bomb_load  = $urandom_range(0, 1);
            bomb_mask  = 9'($urandom) & 9'($urandom) & 9'($urandom);
            seed       = 8'($urandom);
            move_req   = $urandom_range(0, 1);
            move_dir   = 2'($urandom);
            reveal_req = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
